udp_audio_depacketizer: RTL and testbench
=========================================

Name: udp_audio_depacketizer

Overview:
- Receive-side counterpart of the net_top audio packer: takes the UDP receive byte stream from ethernet_test and unpacks it into 16-bit PCM samples.
- Buffers the samples in an internal FIFO with a prefill (jitter) threshold.
- Serves samples to the codec playback path (wav_out_data / wav_rden of mywav).
- Sits between ethernet_test udp_rec_* outputs and the mywav playback input, in the clk domain.

Parameters:
DEPTH, 1024, FIFO depth in samples; power of two.
ADDR_W, 10, log2(DEPTH).
PREFILL, 256, FIFO level at which playback starts or resumes; 1..DEPTH.
UDP_HDR_LEN, 8, bytes subtracted from udp_rec_data_length to get payload length.

Ports:
clk  input  1  system clock (same clock as mywav/net_top).
rst_n  input  1  asynchronous active-low reset.
udp_rec_data_valid  input  1  one payload byte present this cycle.
udp_rec_rdata  input  8  payload byte.
udp_rec_data_length  input  16  UDP length field (header included); stable for whole packet.
wav_rden  input  1  one-cycle request for the next playback sample.
wav_out_data  output  16  current playback sample, registered.
playing  output  1  1 = PLAY state, 0 = BUFFER state.
fifo_level  output  ADDR_W+1  samples currently stored, 0..DEPTH.
overflow_cnt  output  16  samples dropped because FIFO full; saturating.
underrun_cnt  output  16  wav_rden requests served while FIFO empty in PLAY; saturating.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: wav_out_data=0, playing=0, fifo_level=0, overflow_cnt=0, underrun_cnt=0. Parser returns to P_IDLE; FIFO pointers are cleared.
- Reset mid-packet: the remaining bytes of that packet are treated as a new packet.
- Payload format: a sequence of 16-bit signed samples, big-endian (high byte first). No extra header.

Parser FSM (P_IDLE, P_HI, P_LO):
- P_IDLE, valid byte arrives:
  - Compute rem = udp_rec_data_length - UDP_HDR_LEN.
  - If udp_rec_data_length <= UDP_HDR_LEN: discard the byte and stay in P_IDLE.
  - Otherwise: byte becomes the high byte, rem_cnt = rem-1.
  - Next state: P_LO if rem_cnt>0; else P_IDLE, and the lone odd byte is discarded.
- P_LO, valid byte arrives:
  - Assemble {hi,byte} and issue a FIFO write.
  - rem_cnt decrements.
  - Next state: P_IDLE if rem_cnt reaches 0, else P_HI.
- P_HI, valid byte arrives:
  - Latch the high byte; rem_cnt decrements.
  - If rem_cnt reaches 0: the trailing odd byte is discarded and the next state is P_IDLE.
  - Otherwise: next state is P_LO.
- Gaps (valid=0) inside a packet hold the parser state; no timeout.
- A FIFO write occurs in the cycle after the low byte is accepted (1-cycle assemble latency).

FIFO:
- Synchronous, DEPTH entries, binary pointers with wrap at DEPTH.
- fifo_level is updated in the same cycle as the push/pop takes effect.
- Push when full: sample dropped, pointers unchanged, overflow_cnt += 1 (saturate at 16'hFFFF).
- Simultaneous push and pop: both take effect and the level is unchanged.
- Push and pop while full with an accepted pop: both accepted, no overflow.
- The pop is evaluated first.

Playback FSM (BUFFER, PLAY):
- BUFFER:
  - A wav_rden pulse loads wav_out_data=0 and does not pop.
  - When fifo_level >= PREFILL, go to PLAY (checked every cycle).
- PLAY, wav_rden with FIFO non-empty:
  - Pop; the popped sample appears on wav_out_data on the cycle after wav_rden (latency 1).
  - It holds until the next wav_rden.
- PLAY, wav_rden with FIFO empty:
  - wav_out_data=0, underrun_cnt += 1 (saturating).
  - Next state BUFFER.
- playing reflects the registered state.

Arithmetic:
- rem_cnt is 16 bits.
- All counters saturate and never wrap.

Test Plan:
- Reset prefill: reset, send one packet, udp_rec_data_length=8+2*300, samples 0x0000..0x012B. Check:
  - playing rises once fifo_level reaches 256.
  - fifo_level ends at 300.
  - First wav_rden yields 0x0000 one cycle later; the second yields 0x0001.
- Odd length: length=8+5, bytes 12 34 56 78 9A. Check:
  - Exactly 0x1234 and 0x5678 are written.
  - 0x9A is dropped.
  - fifo_level increases by 2.
  - Parser is back in P_IDLE; the next packet parses correctly.
- Short/gapped packets:
  - length=8 with a stray valid byte: nothing written.
  - length=8+4 bytes with 3-cycle valid gaps between bytes: 0xAABB and 0xCCDD written in order.
- Overflow: fill the FIFO to 1024 and send 10 more samples. Check:
  - overflow_cnt=10 and fifo_level=1024.
  - Stored data is the first 1024 samples in order.
  - A simultaneous push+pop when full keeps the level at 1024 and overflow_cnt unchanged.
- Underrun: in PLAY, drain to empty, then pulse wav_rden. Check:
  - wav_out_data=0, underrun_cnt=1, playing=0.
  - Further wav_rden pulses do not increment underrun_cnt.
  - PLAY resumes only after 256 new samples arrive.
- Async reset mid-packet: assert rst_n=0 after 3 payload bytes. Check:
  - All outputs are 0 immediately, without waiting for a clk edge.
  - After release, a new 4-byte packet produces exactly 2 correct samples.

Source files
------------

// File: rtl/udp_audio_depacketizer.sv
// udp_audio_depacketizer: unpacks big-endian UDP PCM bytes into a prefill-gated sample FIFO for playback
`timescale 1ns/1ps
module udp_audio_depacketizer #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int PREFILL     = 256,
    parameter int UDP_HDR_LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              udp_rec_data_valid,
    input  logic [7:0]        udp_rec_rdata,
    input  logic [15:0]       udp_rec_data_length,
    input  logic              wav_rden,
    output logic [15:0]       wav_out_data,
    output logic              playing,
    output logic [ADDR_W:0]   fifo_level,
    output logic [15:0]       overflow_cnt,
    output logic [15:0]       underrun_cnt
);
    typedef enum logic [1:0] {P_IDLE, P_HI, P_LO} p_state_t;
    typedef enum logic {BUFFER, PLAY} pb_state_t;
    p_state_t p_state;
    pb_state_t pb_state;
    logic [7:0] hi;
    logic [15:0] rem, rem_cnt, rem_dec, push_data;
    logic push_req, pop, push_ok, full, empty;
    logic [15:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    assign rem = udp_rec_data_length - 16'(UDP_HDR_LEN);
    assign rem_dec = rem_cnt - 16'd1;
    assign full = fifo_level == (ADDR_W+1)'(DEPTH);
    assign empty = fifo_level == '0;
    assign pop = pb_state == PLAY && wav_rden && !empty;
    assign push_ok = push_req && (!full || pop);
    assign playing = pb_state == PLAY;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state <= P_IDLE;
            hi <= '0;
            rem_cnt <= '0;
            push_req <= 1'b0;
            push_data <= '0;
        end else begin
            push_req <= udp_rec_data_valid && p_state == P_LO;
            if (udp_rec_data_valid)
                case (p_state)
                    P_IDLE: if (udp_rec_data_length > 16'(UDP_HDR_LEN)) begin
                        hi <= udp_rec_rdata;
                        rem_cnt <= rem - 16'd1;
                        p_state <= rem != 16'd1 ? P_LO : P_IDLE;
                    end
                    P_LO: begin
                        push_data <= {hi, udp_rec_rdata};
                        rem_cnt <= rem_dec;
                        p_state <= rem_dec == '0 ? P_IDLE : P_HI;
                    end
                    P_HI: begin
                        hi <= udp_rec_rdata;
                        rem_cnt <= rem_dec;
                        p_state <= rem_dec == '0 ? P_IDLE : P_LO;
                    end
                    default: p_state <= P_IDLE;
                endcase
        end
    end
    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= push_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_level <= '0;
            overflow_cnt <= '0;
            underrun_cnt <= '0;
            wav_out_data <= '0;
            pb_state <= BUFFER;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
            fifo_level <= fifo_level + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop);
            if (push_req && !push_ok && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
            if (pb_state == BUFFER) begin
                if (wav_rden) wav_out_data <= '0;
                if (fifo_level >= (ADDR_W+1)'(PREFILL)) pb_state <= PLAY;
            end else if (wav_rden) begin
                wav_out_data <= empty ? 16'd0 : mem[rd_ptr];
                if (empty) pb_state <= BUFFER;
                if (empty && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_udp_audio_depacketizer.sv
// tb_udp_audio_depacketizer: directed scoreboard bench for udp_audio_depacketizer
`timescale 1ns/1ps
module tb_udp_audio_depacketizer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic udp_rec_data_valid = 1'b0;
    logic [7:0] udp_rec_rdata = '0;
    logic [15:0] udp_rec_data_length = '0;
    logic wav_rden = 1'b0;
    logic [15:0] wav_out_data;
    logic playing;
    logic [10:0] fifo_level;
    logic [15:0] overflow_cnt, underrun_cnt;
    logic [15:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    udp_audio_depacketizer dut (
        .clk(clk), .rst_n(rst_n),
        .udp_rec_data_valid(udp_rec_data_valid), .udp_rec_rdata(udp_rec_rdata),
        .udp_rec_data_length(udp_rec_data_length), .wav_rden(wav_rden),
        .wav_out_data(wav_out_data), .playing(playing), .fifo_level(fifo_level),
        .overflow_cnt(overflow_cnt), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        udp_rec_data_valid = 1'b1;
        udp_rec_rdata = b;
        tick();
        udp_rec_data_valid = 1'b0;
    endtask

    // The FIFO model drops a sample once it already holds 1024
    task automatic send_words(input int n, input logic [15:0] base);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = base + 16'(i);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
            if (exp_q.size() < 1024) exp_q.push_back(w);
        end
    endtask

    task automatic read_expect(input string tag, input bit real_pop);
        logic [15:0] exp;
        exp = real_pop ? exp_q.pop_front() : 16'h0000;
        wav_rden = 1'b1;
        tick();
        wav_rden = 1'b0;
        check(tag, 32'(wav_out_data), 32'(exp));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, 32'(wav_out_data), 0);
        check({tag, "_playing"}, 32'(playing), 0);
        check({tag, "_level"}, 32'(fifo_level), 0);
        check({tag, "_ovf"}, 32'(overflow_cnt), 0);
        check({tag, "_unr"}, 32'(underrun_cnt), 0);
    endtask

    initial begin
        logic [15:0] x;
        #3;
        check_all_zero("reset");
        idle(2);
        rst_n = 1'b1;
        idle(2);
        read_expect("buffer_rden", 1'b0);

        udp_rec_data_length = 16'(8 + 2 * 300);
        send_words(255, 16'h0000);
        idle(3);
        check("prefill_255_level", 32'(fifo_level), 255);
        check("prefill_255_playing", 32'(playing), 0);
        send_words(1, 16'd255);
        idle(3);
        check("prefill_256_playing", 32'(playing), 1);
        send_words(44, 16'd256);
        idle(3);
        check("prefill_level_300", 32'(fifo_level), 300);
        read_expect("first_sample", 1'b1);
        read_expect("second_sample", 1'b1);
        check("after_reads_level", 32'(fifo_level), 298);

        udp_rec_data_length = 16'(8 + 5);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78); send_byte(8'h9A);
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h5678);
        idle(3);
        check("odd_len_level", 32'(fifo_level), 300);
        udp_rec_data_length = 16'(8 + 4);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        exp_q.push_back(16'h1122);
        exp_q.push_back(16'h3344);
        idle(3);
        check("after_odd_level", 32'(fifo_level), 302);

        udp_rec_data_length = 16'd8;
        send_byte(8'hEE);
        idle(3);
        check("short_pkt_level", 32'(fifo_level), 302);
        udp_rec_data_length = 16'(8 + 4);
        send_byte(8'hAA); idle(3); send_byte(8'hBB); idle(3);
        send_byte(8'hCC); idle(3); send_byte(8'hDD);
        exp_q.push_back(16'hAABB);
        exp_q.push_back(16'hCCDD);
        idle(3);
        check("gapped_level", 32'(fifo_level), 304);

        udp_rec_data_length = 16'(8 + 2 * 730);
        send_words(730, 16'h8000);
        idle(3);
        check("overflow_cnt", 32'(overflow_cnt), 10);
        check("overflow_level", 32'(fifo_level), 1024);

        // Low byte accepted one edge before wav_rden so push and pop meet on the same edge
        udp_rec_data_length = 16'(8 + 2);
        send_byte(8'h77);
        udp_rec_data_valid = 1'b1;
        udp_rec_rdata = 8'h77;
        tick();
        udp_rec_data_valid = 1'b0;
        x = exp_q.pop_front();
        exp_q.push_back(16'h7777);
        wav_rden = 1'b1;
        tick();
        wav_rden = 1'b0;
        check("full_pushpop_data", 32'(wav_out_data), 32'(x));
        check("full_pushpop_level", 32'(fifo_level), 1024);
        check("full_pushpop_ovf", 32'(overflow_cnt), 10);
        for (int i = 0; i < 1024; i++) read_expect("drain", 1'b1);
        check("drained_level", 32'(fifo_level), 0);
        check("drained_playing", 32'(playing), 1);

        read_expect("underrun_data", 1'b0);
        check("underrun_cnt", 32'(underrun_cnt), 1);
        check("underrun_playing", 32'(playing), 0);
        read_expect("buffer_again", 1'b0);
        check("underrun_no_inc", 32'(underrun_cnt), 1);
        udp_rec_data_length = 16'(8 + 2 * 255);
        send_words(255, 16'h4000);
        idle(3);
        check("resume_255_playing", 32'(playing), 0);
        udp_rec_data_length = 16'(8 + 2);
        send_words(1, 16'h40FF);
        idle(3);
        check("resume_256_playing", 32'(playing), 1);
        read_expect("resume_first", 1'b1);

        udp_rec_data_length = 16'(8 + 8);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        udp_rec_data_length = 16'(8 + 4);
        send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D);
        exp_q.push_back(16'h0A0B);
        exp_q.push_back(16'h0C0D);
        idle(3);
        check("post_reset_level", 32'(fifo_level), 2);
        udp_rec_data_length = 16'(8 + 2 * 254);
        send_words(254, 16'h5000);
        idle(3);
        check("post_reset_playing", 32'(playing), 1);
        read_expect("post_reset_s0", 1'b1);
        read_expect("post_reset_s1", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
